// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   One requester's view of the DMEM arbiter: an independent write channel and
//   read channel, each with a valid/ready handshake, plus the read response.
//
//   master modport : requester side (drives requests, receives ready/response)
//   slave modport  : arbiter side
//
//   wr_valid  write request, held stable until wr_ready
//   wr_addr   byte address of the write
//   wr_data   write data
//   wr_ready  write granted this cycle (combinational)
//   rd_valid  read request, held stable until rd_ready
//   rd_addr   byte address of the read
//   rd_ready  read accepted this cycle (combinational)
//   rd_rvalid read data valid, one cycle after acceptance
//   rd_data   read data, zero while rd_rvalid is low
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              wr_valid;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [31:0]       rd_addr;
  logic              rd_ready;
  logic              rd_rvalid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rd_rvalid, rd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rd_rvalid, rd_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter in front of the simple-dual-port data RAM (one write
//   port, one read port). The write and read channels are arbitrated
//   independently, each with 1-bit round-robin state, so one write and one
//   read can be serviced every cycle. Only byte addresses with
//   addr[31:16] == 0 decode to DMEM; other requests are never granted.
//
//   Optional feature macro: DMEM_ARB_FWD_EN
//     defined   : a read accepted in the same cycle as a write to the same word
//                 returns the new write data (bypasses the read-first RAM).
//     undefined : such a read returns the old RAM contents.
//
// Ports
//   clk        single clock for the arbiter and the RAM
//   rst        synchronous, active-high reset
//   m0, m1     requester interfaces (m0 = core LSU, m1 = DMA/debug)
//   ram_we     RAM write enable (all byte lanes)
//   ram_waddr  RAM write word address
//   ram_wdata  RAM write data
//   ram_raddr  RAM read word address (holds its value when no read is issued)
//   ram_rdata  RAM read data, valid one cycle after ram_raddr
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       m0,
  dmem_arbiter_if.slave       m1,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_waddr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [ADDR_W-1:0]   ram_raddr,
  input  logic [DATA_W-1:0]   ram_rdata
);

  // The response path below is built for a single-cycle RAM only.
  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("dmem_arbiter: only RD_LAT == 1 is supported");
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [1:0] wr_req;
  logic [1:0] rd_req;

  assign wr_req[0] = m0.wr_valid && (m0.wr_addr[31:16] == 16'h0000);
  assign wr_req[1] = m1.wr_valid && (m1.wr_addr[31:16] == 16'h0000);
  assign rd_req[0] = m0.rd_valid && (m0.rd_addr[31:16] == 16'h0000);
  assign rd_req[1] = m1.rd_valid && (m1.rd_addr[31:16] == 16'h0000);

  // Byte-offset bits and the unused top of the DMEM window never reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0.wr_addr, m1.wr_addr, m0.rd_addr, m1.rd_addr};

  // ---------------------------------------------------------------------------
  // Round-robin grant
  // ---------------------------------------------------------------------------
  logic       wr_last;
  logic       rd_last;
  logic [1:0] wr_gnt;
  logic [1:0] rd_gnt;

  // On a conflict the requester that did not win last time is granted.
  // last == 1 favours m0, last == 0 favours m1.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    return gnt;
  endfunction

  // NOTE: every signal written in always_comb gets a value on every path
  // (here via the first assignment), so no latch can be inferred.
  always_comb begin
    wr_gnt = 2'b00;
    rd_gnt = 2'b00;
    if (!rst) begin
      wr_gnt = rr_pick(wr_req, wr_last);
      rd_gnt = rr_pick(rd_req, rd_last);
    end
  end

  assign m0.wr_ready = wr_gnt[0];
  assign m1.wr_ready = wr_gnt[1];
  assign m0.rd_ready = rd_gnt[0];
  assign m1.rd_ready = rd_gnt[1];

  // ---------------------------------------------------------------------------
  // Write channel: the write completes in the grant cycle.
  // ---------------------------------------------------------------------------
  logic wr_fire;
  logic wr_sel;

  assign wr_fire   = |wr_gnt;
  assign wr_sel    = wr_gnt[1];
  assign ram_we    = wr_fire;
  assign ram_waddr = wr_sel ? m1.wr_addr[ADDR_W+1:2] : m0.wr_addr[ADDR_W+1:2];
  assign ram_wdata = wr_sel ? m1.wr_data : m0.wr_data;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic              rd_fire;
  logic              rd_sel;
  logic [ADDR_W-1:0] rd_word;
  logic [ADDR_W-1:0] raddr_q;
  logic              rd_pend;
  logic              rd_own;

  assign rd_fire   = |rd_gnt;
  assign rd_sel    = rd_gnt[1];
  assign rd_word   = rd_sel ? m1.rd_addr[ADDR_W+1:2] : m0.rd_addr[ADDR_W+1:2];
  assign ram_raddr = rd_fire ? rd_word : raddr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_last <= 1'b1;
      rd_last <= 1'b1;
      rd_pend <= 1'b0;
      rd_own  <= 1'b0;
      raddr_q <= '0;
    end else begin
      if (wr_fire) wr_last <= wr_sel;
      if (rd_fire) begin
        rd_last <= rd_sel;
        rd_own  <= rd_sel;
        raddr_q <= rd_word;
      end
      rd_pend <= rd_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Read response: one cycle after acceptance, to the owner only.
  // ---------------------------------------------------------------------------
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  // A response due in a reset cycle is dropped outright.
  assign rsp_valid = rd_pend && !rst;

`ifdef DMEM_ARB_FWD_EN
  logic              fwd_hit_q;
  logic [DATA_W-1:0] fwd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_q <= 1'b0;
    end else begin
      fwd_hit_q <= wr_fire && rd_fire && (ram_waddr == rd_word);
    end
  end

  // NOTE: data-path registers are left out of reset; fwd_hit_q alone
  // qualifies fwd_data_q, so its power-up value is never observed.
  always_ff @(posedge clk) begin
    if (wr_fire) fwd_data_q <= ram_wdata;
  end

  assign rsp_data = fwd_hit_q ? fwd_data_q : ram_rdata;
`else
  assign rsp_data = ram_rdata;
`endif

  assign m0.rd_rvalid = rsp_valid && !rd_own;
  assign m1.rd_rvalid = rsp_valid &&  rd_own;
  assign m0.rd_data   = (rsp_valid && !rd_own) ? rsp_data : '0;
  assign m1.rd_data   = (rsp_valid &&  rd_own) ? rsp_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Drives two requester interfaces against dmem_arbiter with a behavioural
//   read-first RAM. A negedge monitor checks every cycle: grant legality, RAM
//   write port contents, and read responses against a scoreboard queue of
//   expected (owner, data, due cycle) entries built from a reference memory.
//   Directed sequences add cycle-exact checks on grants and responses.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DATA_W)) m0_if ();
  dmem_arbiter_if #(.DATA_W(DATA_W)) m1_if ();

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata)
  );

  // Behavioural read-first RAM, one cycle read latency.
  logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = '0;
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_raddr];
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t     sb_q [$];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_read(input int word);
    return ref_mem.exists(word) ? ref_mem[word] : 32'h0;
  endfunction

  function automatic logic is_hit(input logic [31:0] addr);
    return addr[31:16] == 16'h0000;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    rd_exp_t     e;
    rd_exp_t     n;
    logic        wr_fire;
    int          wr_word;
    logic [31:0] wr_val;
    int          rd_word;
    logic [31:0] rd_val;

    if (rst) begin
      check("rst_m0_wr_ready", 32'(m0_if.wr_ready), 32'd0);
      check("rst_m1_wr_ready", 32'(m1_if.wr_ready), 32'd0);
      check("rst_m0_rd_ready", 32'(m0_if.rd_ready), 32'd0);
      check("rst_m1_rd_ready", 32'(m1_if.rd_ready), 32'd0);
      check("rst_rvalid", 32'({m1_if.rd_rvalid, m0_if.rd_rvalid}), 32'd0);
      check("rst_rd_data", m0_if.rd_data | m1_if.rd_data, 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      sb_q.delete();
    end else begin
      // Responses
      if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        check("rsp_owner_rvalid", 32'(e.owner ? m1_if.rd_rvalid : m0_if.rd_rvalid), 32'd1);
        check("rsp_other_rvalid", 32'(e.owner ? m0_if.rd_rvalid : m1_if.rd_rvalid), 32'd0);
        check("rsp_data", e.owner ? m1_if.rd_data : m0_if.rd_data, e.data);
        check("rsp_other_data", e.owner ? m0_if.rd_data : m1_if.rd_data, 32'd0);
      end else begin
        check("idle_rvalid", 32'({m1_if.rd_rvalid, m0_if.rd_rvalid}), 32'd0);
        check("idle_rd_data", m0_if.rd_data | m1_if.rd_data, 32'd0);
      end

      // Grant legality
      check("wr_one_hot", 32'(m0_if.wr_ready & m1_if.wr_ready), 32'd0);
      check("rd_one_hot", 32'(m0_if.rd_ready & m1_if.rd_ready), 32'd0);
      check("m0_wr_ready_elig", 32'(m0_if.wr_ready & ~(m0_if.wr_valid & is_hit(m0_if.wr_addr))), 32'd0);
      check("m1_wr_ready_elig", 32'(m1_if.wr_ready & ~(m1_if.wr_valid & is_hit(m1_if.wr_addr))), 32'd0);
      check("m0_rd_ready_elig", 32'(m0_if.rd_ready & ~(m0_if.rd_valid & is_hit(m0_if.rd_addr))), 32'd0);
      check("m1_rd_ready_elig", 32'(m1_if.rd_ready & ~(m1_if.rd_valid & is_hit(m1_if.rd_addr))), 32'd0);

      // Write port
      wr_fire = m0_if.wr_ready | m1_if.wr_ready;
      wr_word = m1_if.wr_ready ? int'(m1_if.wr_addr[ADDR_W+1:2]) : int'(m0_if.wr_addr[ADDR_W+1:2]);
      wr_val  = m1_if.wr_ready ? m1_if.wr_data : m0_if.wr_data;
      check("ram_we", 32'(ram_we), 32'(wr_fire));
      if (wr_fire) begin
        check("ram_waddr", 32'(ram_waddr), 32'(wr_word));
        check("ram_wdata", ram_wdata, wr_val);
      end

      // Read acceptance: expectation uses memory state before this cycle's write.
      if (m0_if.rd_ready || m1_if.rd_ready) begin
        rd_word = m1_if.rd_ready ? int'(m1_if.rd_addr[ADDR_W+1:2]) : int'(m0_if.rd_addr[ADDR_W+1:2]);
        check("ram_raddr", 32'(ram_raddr), 32'(rd_word));
        rd_val = ref_read(rd_word);
`ifdef DMEM_ARB_FWD_EN
        if (wr_fire && wr_word == rd_word) rd_val = wr_val;
`endif
        n.owner = m1_if.rd_ready;
        n.data  = rd_val;
        n.due   = cyc + 1;
        sb_q.push_back(n);
      end

      if (wr_fire) ref_mem[wr_word] = wr_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_if.wr_valid = 1'b0; m0_if.rd_valid = 1'b0;
    m1_if.wr_valid = 1'b0; m1_if.rd_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] exp_fwd;

  initial begin
    m0_if.wr_addr = '0; m0_if.wr_data = '0; m0_if.rd_addr = '0;
    m1_if.wr_addr = '0; m1_if.wr_data = '0; m1_if.rd_addr = '0;
    reset_dut();

    // 1: write then read back through m0.
    m0_if.wr_valid = 1'b1; m0_if.wr_addr = 32'h0000_0010; m0_if.wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1_m0_wr_ready", 32'(m0_if.wr_ready), 32'd1);
    next_cycle();
    m0_if.wr_valid = 1'b0;
    m0_if.rd_valid = 1'b1; m0_if.rd_addr = 32'h0000_0010;
    @(negedge clk);
    check("t1_m0_rd_ready", 32'(m0_if.rd_ready), 32'd1);
    next_cycle();
    m0_if.rd_valid = 1'b0;
    @(negedge clk);
    check("t1_m0_rvalid", 32'(m0_if.rd_rvalid), 32'd1);
    check("t1_m0_rd_data", m0_if.rd_data, 32'hDEAD_BEEF);

    // 2: write conflict alternates m0, m1, m0, m1 after reset.
    next_cycle();
    reset_dut();
    m0_if.wr_valid = 1'b1; m0_if.wr_addr = 32'h0000_0100; m0_if.wr_data = 32'hAAAA_0000;
    m1_if.wr_valid = 1'b1; m1_if.wr_addr = 32'h0000_0200; m1_if.wr_data = 32'hBBBB_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_m0_wr_ready", 32'(m0_if.wr_ready), 32'(i % 2 == 0));
      check("t2_m1_wr_ready", 32'(m1_if.wr_ready), 32'(i % 2 == 1));
      check("t2_ram_we", 32'(ram_we), 32'd1);
      next_cycle();
      m0_if.wr_data = m0_if.wr_data + 1;
      m1_if.wr_data = m1_if.wr_data + 1;
    end
    idle_all();

    // 3: out-of-window read is never accepted; out-of-window write never wins.
    m1_if.rd_valid = 1'b1; m1_if.rd_addr = 32'h0001_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_m1_rd_ready", 32'(m1_if.rd_ready), 32'd0);
      check("t3_ram_we", 32'(ram_we), 32'd0);
      check("t3_m1_rvalid", 32'(m1_if.rd_rvalid), 32'd0);
      next_cycle();
    end
    idle_all();
    m0_if.wr_valid = 1'b1; m0_if.wr_addr = 32'h0002_0040; m0_if.wr_data = 32'h0BAD_0BAD;
    m1_if.wr_valid = 1'b1; m1_if.wr_addr = 32'h0000_0040; m1_if.wr_data = 32'h600D_600D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_m0_wr_ready", 32'(m0_if.wr_ready), 32'd0);
      check("t3_m1_wr_ready", 32'(m1_if.wr_ready), 32'd1);
      next_cycle();
    end
    idle_all();

    // 4: same-cycle write and read of one word.
    m0_if.wr_valid = 1'b1; m0_if.wr_addr = 32'h0000_0020; m0_if.wr_data = 32'h1111_1111;
    @(negedge clk);
    check("t4_pre_wr_ready", 32'(m0_if.wr_ready), 32'd1);
    next_cycle();
    m0_if.wr_data  = 32'h2222_2222;
    m1_if.rd_valid = 1'b1; m1_if.rd_addr = 32'h0000_0020;
    @(negedge clk);
    check("t4_m0_wr_ready", 32'(m0_if.wr_ready), 32'd1);
    check("t4_m1_rd_ready", 32'(m1_if.rd_ready), 32'd1);
    next_cycle();
    idle_all();
`ifdef DMEM_ARB_FWD_EN
    exp_fwd = 32'h2222_2222;
`else
    exp_fwd = 32'h1111_1111;
`endif
    @(negedge clk);
    check("t4_m1_rvalid", 32'(m1_if.rd_rvalid), 32'd1);
    check("t4_m1_rd_data", m1_if.rd_data, exp_fwd);

    // 5: reset kills an in-flight read; first post-reset conflict goes to m0.
    next_cycle();
    m0_if.wr_valid = 1'b1; m0_if.wr_addr = 32'h0000_0030; m0_if.wr_data = 32'h3030_3030;
    m1_if.rd_valid = 1'b1; m1_if.rd_addr = 32'h0000_0010;
    @(negedge clk);
    check("t5_m1_rd_ready", 32'(m1_if.rd_ready), 32'd1);
    check("t5_m0_wr_ready", 32'(m0_if.wr_ready), 32'd1);
    next_cycle();
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_m1_rvalid", 32'(m1_if.rd_rvalid), 32'd0);
    next_cycle();
    rst = 1'b0;
    m0_if.wr_valid = 1'b1; m0_if.wr_addr = 32'h0000_0040; m0_if.wr_data = 32'h4040_4040;
    m1_if.wr_valid = 1'b1; m1_if.wr_addr = 32'h0000_0044; m1_if.wr_data = 32'h4444_4444;
    m0_if.rd_valid = 1'b1; m0_if.rd_addr = 32'h0000_0010;
    m1_if.rd_valid = 1'b1; m1_if.rd_addr = 32'h0000_0014;
    @(negedge clk);
    check("t5_post_m1_rvalid", 32'(m1_if.rd_rvalid), 32'd0);
    check("t5_post_m0_wr_ready", 32'(m0_if.wr_ready), 32'd1);
    check("t5_post_m1_wr_ready", 32'(m1_if.wr_ready), 32'd0);
    check("t5_post_m0_rd_ready", 32'(m0_if.rd_ready), 32'd1);
    check("t5_post_m1_rd_ready", 32'(m1_if.rd_ready), 32'd0);
    next_cycle();
    idle_all();

    // 6: preload eight words, then alternate m0/m1 reads back-to-back.
    for (int i = 0; i < 8; i++) begin
      m1_if.wr_valid = 1'b1;
      m1_if.wr_addr  = 32'h0000_0400 + 32'(4 * i);
      m1_if.wr_data  = 32'hA500_0000 + 32'(i * 17);
      @(negedge clk);
      check("t6_preload_ready", 32'(m1_if.wr_ready), 32'd1);
      next_cycle();
    end
    idle_all();
    for (int i = 0; i < 8; i++) begin
      m0_if.rd_valid = (i % 2 == 0);
      m1_if.rd_valid = (i % 2 == 1);
      m0_if.rd_addr  = 32'h0000_0400 + 32'(4 * i);
      m1_if.rd_addr  = 32'h0000_0400 + 32'(4 * i);
      @(negedge clk);
      check("t6_rd_ready", 32'((i % 2 == 0) ? m0_if.rd_ready : m1_if.rd_ready), 32'd1);
      if (i > 0)
        check("t6_no_bubble", 32'((i % 2 == 1) ? m0_if.rd_rvalid : m1_if.rd_rvalid), 32'd1);
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    check("t6_last_rvalid", 32'(m1_if.rd_rvalid), 32'd1);

    repeat (2) next_cycle();
    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
